// File: rtl/debounce_multi.sv
// ============================================================================
//  Module      : debounce_multi
//  Description : Multi-channel switch debouncer. Each raw input is
//                synchronised through two flops and sampled on a shared
//                prescaled tick; a channel's debounced level changes only
//                after STABLE_CNT consecutive ticks that disagree with it.
//                One-cycle RISE/FALL pulses accompany every accepted change.
//
//  Ports       : CLK     - system clock, rising edge
//                RESET   - synchronous, active-high reset
//                SW_IN   - raw asynchronous switch levels   [N_CH]
//                SW_OUT  - debounced levels                 [N_CH]
//                RISE    - 1-cycle pulse on SW_OUT 0->1      [N_CH]
//                FALL    - 1-cycle pulse on SW_OUT 1->0      [N_CH]
//                TICK    - 1-cycle sample strobe
//                LONG    - 1-cycle long-press pulse         [N_CH]
//
//  Build option: DEBOUNCE_LONG_PRESS_EN - when defined, per-channel hold
//                counters drive LONG; when undefined LONG is tied to 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi #(
    parameter int   N_CH       = 4,
    parameter int   TICK_DIV   = 100000,
    parameter int   STABLE_CNT = 10,
    parameter logic RST_VAL    = 1'b0,
    parameter int   LONG_TICKS = 1000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_CH-1:0] SW_IN,
    output logic [N_CH-1:0] SW_OUT,
    output logic [N_CH-1:0] RISE,
    output logic [N_CH-1:0] FALL,
    output logic            TICK,
    output logic [N_CH-1:0] LONG
);

    localparam int c_PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int c_CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [c_PW-1:0] c_DIV_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(STABLE_CNT - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= {N_CH{RST_VAL}};
            r_sync2 <= {N_CH{RST_VAL}};
        end else begin
            r_sync1 <= SW_IN;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Shared prescaler; TICK is registered so it is high in the cycle
    // following the wrap, which is the cycle the channels act on.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_pre;
    logic            r_tick;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (r_pre == c_DIV_MAX) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_pre  <= r_pre + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign TICK = r_tick;

    // ------------------------------------------------------------------
    // Per-channel acceptance counters
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [c_CW-1:0] r_cnt;
        logic            r_out;
        logic            r_rise;
        logic            r_fall;

        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_cnt  <= '0;
                r_out  <= RST_VAL;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (r_tick) begin
                    if (r_sync2[g] == r_out) begin
                        // Any agreeing tick throws away partial progress.
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_out  <= r_sync2[g];
                        r_cnt  <= '0;
                        r_rise <= r_sync2[g];
                        r_fall <= ~r_sync2[g];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign SW_OUT[g] = r_out;
        assign RISE[g]   = r_rise;
        assign FALL[g]   = r_fall;

`ifdef DEBOUNCE_LONG_PRESS_EN
        localparam int c_LW = $clog2(LONG_TICKS + 1);
        localparam logic [c_LW-1:0] c_LONG_MAX = c_LW'(LONG_TICKS);

        logic [c_LW-1:0] r_hold;
        logic            r_long;

        // Saturating at LONG_TICKS makes the pulse fire once per press.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (!r_out) begin
                    r_hold <= '0;
                end else if (r_tick && (r_hold != c_LONG_MAX)) begin
                    r_hold <= r_hold + 1'b1;
                    if (r_hold == c_LONG_MAX - 1'b1) begin
                        r_long <= 1'b1;
                    end
                end
            end
        end

        assign LONG[g] = r_long;
`else
        assign LONG[g] = 1'b0;
`endif
    end

`ifndef DEBOUNCE_LONG_PRESS_EN
    // LONG_TICKS only sizes the hold counters; this empty block keeps the
    // parameter referenced when they are not built.
    if (LONG_TICKS < 1) begin : g_long_ticks_unused
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_debounce_multi.sv
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Self-checking bench for debounce_multi (N_CH=2, TICK_DIV=4,
//                STABLE_CNT=3, LONG_TICKS=5). Directed scenarios followed by
//                randomized switch activity, all checked cycle by cycle
//                against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_multi;

    localparam int c_N  = 2;
    localparam int c_TD = 4;
    localparam int c_SC = 3;
    localparam int c_LT = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [c_N-1:0] sw_in;
    logic [c_N-1:0] sw_out;
    logic [c_N-1:0] rise;
    logic [c_N-1:0] fall;
    logic           tick;
    logic [c_N-1:0] lng;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH       (c_N),
        .TICK_DIV   (c_TD),
        .STABLE_CNT (c_SC),
        .RST_VAL    (1'b0),
        .LONG_TICKS (c_LT)
    ) u_dut (
        .CLK    (clk),
        .RESET  (rst),
        .SW_IN  (sw_in),
        .SW_OUT (sw_out),
        .RISE   (rise),
        .FALL   (fall),
        .TICK   (tick),
        .LONG   (lng)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: input history, cycles since reset, and a count
    // of consecutive disagreeing ticks per channel.
    // ------------------------------------------------------------------
    logic [c_N-1:0] m_hist [2];   // [0] = last cycle's SW_IN, [1] = two cycles ago
    logic [c_N-1:0] m_out, m_rise, m_fall, m_long;
    logic           m_tick;
    int             m_since;
    int             m_run  [c_N];
    int             m_hold [c_N];

    task automatic model_step(input logic r, input logic [c_N-1:0] s);
        logic [c_N-1:0] seen;
        logic [c_N-1:0] prev;
        logic           tnow;
        if (r) begin
            m_hist[0] = '0; m_hist[1] = '0;
            m_out = '0; m_rise = '0; m_fall = '0; m_long = '0;
            m_tick = 1'b0; m_since = 0;
            for (int c = 0; c < c_N; c++) begin
                m_run[c] = 0; m_hold[c] = 0;
            end
        end else begin
            seen = m_hist[1];
            prev = m_out;
            tnow = m_tick;
            m_rise = '0; m_fall = '0; m_long = '0;
            m_hist[1] = m_hist[0];
            m_hist[0] = s;
            m_since++;
            m_tick = ((m_since % c_TD) == 0);
            for (int c = 0; c < c_N; c++) begin
                if (tnow) begin
                    if (seen[c] != prev[c]) begin
                        m_run[c]++;
                        if (m_run[c] == c_SC) begin
                            m_out[c] = seen[c];
                            m_run[c] = 0;
                            if (seen[c]) m_rise[c] = 1'b1;
                            else         m_fall[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
`ifdef DEBOUNCE_LONG_PRESS_EN
                if (!prev[c]) begin
                    m_hold[c] = 0;
                end else if (tnow && m_hold[c] < c_LT) begin
                    m_hold[c]++;
                    if (m_hold[c] == c_LT) m_long[c] = 1'b1;
                end
`endif
            end
        end
    endtask

    int n_rise [c_N];
    int n_fall [c_N];
    int n_long [c_N];

    // One clock: drive inputs, advance model, compare after the edge.
    task automatic cyc(input logic r, input logic [c_N-1:0] s);
        rst   = r;
        sw_in = s;
        model_step(r, s);
        @(posedge clk);
        @(negedge clk);
        chk("sw_out", 32'(sw_out), 32'(m_out));
        chk("rise",   32'(rise),   32'(m_rise));
        chk("fall",   32'(fall),   32'(m_fall));
        chk("tick",   32'(tick),   32'(m_tick));
        chk("long",   32'(lng),    32'(m_long));
        for (int c = 0; c < c_N; c++) begin
            n_rise[c] += int'(rise[c]);
            n_fall[c] += int'(fall[c]);
            n_long[c] += int'(lng[c]);
        end
    endtask

    task automatic clr_counts();
        for (int c = 0; c < c_N; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0;
        end
    endtask

    initial begin
        int first_tick;
        logic both_r, both_f;
        logic [c_N-1:0] rs;

        clr_counts();

        // Reset with inputs high: outputs stay at reset level.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b11);
            chk("rst_out",  32'(sw_out), 32'd0);
            chk("rst_edge", 32'({rise, fall, lng, tick}), 32'd0);
        end

        // First tick lands TICK_DIV cycles after release.
        first_tick = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 2'b00);
            if (tick && first_tick == 0) first_tick = i;
        end
        chk("first_tick", 32'(first_tick), 32'(c_TD));

        // Clean press on channel 0.
        clr_counts();
        for (int i = 0; i < 20; i++) cyc(1'b0, 2'b01);
        chk("press_out",   32'(sw_out),    32'b01);
        chk("press_rise0", 32'(n_rise[0]), 32'd1);
        chk("press_ch1",   32'(n_rise[1] + n_fall[1]), 32'd0);

        // Chatter: level flips every 5 cycles, never 3 ticks in a row.
        clr_counts();
        for (int i = 0; i < 60; i++) cyc(1'b0, ((i / 5) % 2 == 0) ? 2'b00 : 2'b01);
        chk("chat_out",   32'(sw_out), 32'b01);
        chk("chat_edges", 32'(n_rise[0] + n_fall[0]), 32'd0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 2'b00);
        chk("chat_settle", 32'(n_fall[0]), 32'd1);

        // Both channels together.
        both_r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 2'b11);
            if (rise == 2'b11) both_r = 1'b1;
        end
        chk("both_rise", 32'(both_r), 32'd1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 2'b11);
        both_f = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 2'b00);
            if (fall == 2'b11) both_f = 1'b1;
        end
        chk("both_fall", 32'(both_f), 32'd1);

        // Reset part way through a count on channel 1.
        for (int i = 0; i < 9; i++) cyc(1'b0, 2'b10);
        cyc(1'b1, 2'b10);
        chk("midrst_out", 32'(sw_out), 32'd0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 2'b10);
        chk("midrst_wait", 32'(sw_out), 32'd0);
        cyc(1'b0, 2'b10);
        chk("midrst_acc", 32'(sw_out), 32'b10);

        // Long hold on channel 1.
        clr_counts();
        for (int i = 0; i < 60; i++) cyc(1'b0, 2'b10);
`ifdef DEBOUNCE_LONG_PRESS_EN
        chk("long_once", 32'(n_long[1]), 32'd1);
`else
        chk("long_off", 32'(n_long[1]), 32'd0);
`endif
        for (int i = 0; i < 20; i++) cyc(1'b0, 2'b00);

        // Randomized activity with varying flip rates and rare resets.
        rs = 2'b00;
        for (int seg = 0; seg < 6; seg++) begin
            int rate;
            rate = 4 + seg * 6;
            for (int i = 0; i < 500; i++) begin
                for (int c = 0; c < c_N; c++)
                    if ($urandom_range(rate - 1, 0) == 0) rs[c] = ~rs[c];
                cyc(($urandom_range(499, 0) == 0), rs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
